// File: rtl/load_align_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_align_unit
//  Purpose  : MEM-stage load path. Accepts one load per cycle, reads a
//             synchronous word-wide data memory, extracts and extends the
//             addressed byte/half/word (little-endian) and registers the
//             result for writeback. Loads that straddle a word boundary are
//             split into two word reads with a single-cycle upstream stall.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             req_valid/funct3/addr/rd - load request (taken when stall==0)
//             mem_re, mem_addr         - memory read strobe / word address
//             mem_rdata                - read data, valid one cycle after re
//             stall                    - request not accepted this cycle
//             wb_valid/rd/data/err     - registered writeback result
//  Revision : 1.0  initial release
// ============================================================================
module load_align_unit #(
  parameter int AW  = 32,
  parameter int RDW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      req_funct3,
  input  logic [AW-1:0]   req_addr,
  input  logic [RDW-1:0]  req_rd,
  output logic            mem_re,
  output logic [AW-3:0]   mem_addr,
  input  logic [31:0]     mem_rdata,
  output logic            stall,
  output logic            wb_valid,
  output logic [RDW-1:0]  wb_rd,
  output logic [31:0]     wb_data,
  output logic            wb_err
);

  localparam logic [2:0]    c_F3_LB   = 3'b000;
  localparam logic [2:0]    c_F3_LH   = 3'b001;
  localparam logic [2:0]    c_F3_LW   = 3'b010;
  localparam logic [2:0]    c_F3_LBU  = 3'b100;
  localparam logic [2:0]    c_F3_LHU  = 3'b101;
  localparam logic [AW-3:0] c_WORD_ONE = {{(AW-3){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_WAIT2 = 2'd2
  } state_t;

  state_t          r_state;
  logic [2:0]      r_f3;
  logic [1:0]      r_off;
  logic [RDW-1:0]  r_rd;
  logic            r_split;
  logic [AW-3:0]   r_waddr;
  logic [31:0]     r_word0;

  logic            w_accept;
  logic            w_split;
  logic            w_result_now;
  logic [31:0]     w_lo;
  logic [23:0]     w_hi;
  logic [55:0]     w_pair;
  logic [31:0]     w_v;
  logic [31:0]     w_ext;
  logic            w_err;

  // Stall depends only on registered state so there is no combinational
  // path from the request inputs back to the upstream stage.
  assign stall    = (r_state == ST_WAIT1) && r_split;
  assign w_accept = req_valid && !stall && !rst;

  // A load splits when its bytes run past the end of the addressed word.
  // Illegal funct3 values never split.
  always_comb begin
    w_split = 1'b0;
    case (req_funct3)
      c_F3_LW:           w_split = (req_addr[1:0] != 2'b00);
      c_F3_LH, c_F3_LHU: w_split = (req_addr[1:0] == 2'b11);
      default:           w_split = 1'b0;
    endcase
  end

  // The second read of a split load reuses the port while stalled; the
  // word address wraps naturally at the top of the address space.
  assign mem_re   = !rst && (w_accept || stall);
  assign mem_addr = stall ? (r_waddr + c_WORD_ONE) : req_addr[AW-1:2];

  // A result is formed in WAIT1 for single-word loads and in WAIT2 for the
  // second half of a split load.
  assign w_result_now = ((r_state == ST_WAIT1) && !r_split) || (r_state == ST_WAIT2);

  // Two-word window: low word is the first read, high bytes come from the
  // second read (zero for non-split loads). Only 24 high bits can ever be
  // reached because the byte offset is at most 3.
  always_comb begin
    w_lo = mem_rdata;
    w_hi = 24'd0;
    if (r_state == ST_WAIT2) begin
      w_lo = r_word0;
      w_hi = mem_rdata[23:0];
    end
  end

  assign w_pair = {w_hi, w_lo};

  always_comb begin
    w_v = w_pair[31:0];
    case (r_off)
      2'd0: w_v = w_pair[31:0];
      2'd1: w_v = w_pair[39:8];
      2'd2: w_v = w_pair[47:16];
      2'd3: w_v = w_pair[55:24];
      default: w_v = w_pair[31:0];
    endcase
  end

  always_comb begin
    w_ext = 32'd0;
    w_err = 1'b0;
    case (r_f3)
      c_F3_LB:  w_ext = {{24{w_v[7]}}, w_v[7:0]};
      c_F3_LBU: w_ext = {24'd0, w_v[7:0]};
      c_F3_LH:  w_ext = {{16{w_v[15]}}, w_v[15:0]};
      c_F3_LHU: w_ext = {16'd0, w_v[15:0]};
      c_F3_LW:  w_ext = w_v;
      default: begin
        w_ext = 32'd0;
        w_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_f3     <= 3'd0;
      r_off    <= 2'd0;
      r_rd     <= '0;
      r_split  <= 1'b0;
      r_waddr  <= '0;
      r_word0  <= 32'd0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= 32'd0;
      wb_err   <= 1'b0;
    end else begin
      if (stall) begin
        r_word0 <= mem_rdata;
      end

      if (w_result_now) begin
        wb_valid <= 1'b1;
        wb_rd    <= r_rd;
        wb_data  <= w_ext;
        wb_err   <= w_err;
      end else begin
        wb_valid <= 1'b0;
      end

      if (w_accept) begin
        r_state <= ST_WAIT1;
        r_f3    <= req_funct3;
        r_off   <= req_addr[1:0];
        r_rd    <= req_rd;
        r_split <= w_split;
        r_waddr <= req_addr[AW-1:2];
      end else if (stall) begin
        r_state <= ST_WAIT2;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_align_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_align_unit
//  Purpose  : Self-checking bench for load_align_unit. A byte-level reference
//             model predicts stall, memory strobes and writeback results
//             cycle by cycle for directed and random load sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [4:0]  req_rd;
  logic        mem_re;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;

  load_align_unit #(.AW(32), .RDW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_rd     (req_rd),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_err     (wb_err)
  );

  always #5 clk = ~clk;

  // Synchronous memory: 256 words, aliased over the full word address space.
  logic [31:0] mem [256];
  initial mem_rdata = 32'd0;
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
  end

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          ncmp = 0;
  int          nfail = 0;
  int          cyc = 0;
  logic        m_stall = 1'b0;
  logic [31:0] m_waddr = 32'd0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_data = 32'd0;
  logic        m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return w[8*a[1:0] +: 8];
  endfunction

  // One clock cycle: drive inputs, check combinational outputs, step the
  // clock, then check the registered writeback against the model.
  task automatic cycle(input logic r, input logic v, input logic [2:0] f3,
                       input logic [31:0] a, input logic [4:0] rd);
    logic        acc;
    logic        nstall;
    int          size;
    logic [31:0] d;
    logic        e;
    logic [7:0]  b0, b1, b2, b3;
    exp_t        ent;
    logic        ev;

    rst = r; req_valid = v; req_funct3 = f3; req_addr = a; req_rd = rd;
    #1;
    chk("stall", {31'd0, stall}, {31'd0, m_stall});
    acc = !r && v && !m_stall;
    chk("mem_re", {31'd0, mem_re}, {31'd0, !r && (acc || m_stall)});
    if (acc)
      chk("mem_addr", {2'b00, mem_addr}, a >> 2);
    else if (!r && m_stall)
      chk("mem_addr2", {2'b00, mem_addr}, (m_waddr + 32'd1) & 32'h3FFF_FFFF);

    nstall = 1'b0;
    if (r) begin
      q.delete();
      m_rd = 5'd0; m_data = 32'd0; m_err = 1'b0;
    end else if (acc) begin
      case (f3)
        3'b000, 3'b100: size = 1;
        3'b001, 3'b101: size = 2;
        3'b010:         size = 4;
        default:        size = 0;
      endcase
      b0 = byte_at(a); b1 = byte_at(a + 32'd1);
      b2 = byte_at(a + 32'd2); b3 = byte_at(a + 32'd3);
      e = 1'b0;
      case (f3)
        3'b000:  d = {{24{b0[7]}}, b0};
        3'b100:  d = {24'd0, b0};
        3'b001:  d = {{16{b1[7]}}, b1, b0};
        3'b101:  d = {16'd0, b1, b0};
        3'b010:  d = {b3, b2, b1, b0};
        default: begin d = 32'd0; e = 1'b1; end
      endcase
      nstall = (size != 0) && (int'(a[1:0]) + size > 4);
      m_waddr = a >> 2;
      ent.due = cyc + (nstall ? 3 : 2);
      ent.rd = rd; ent.data = d; ent.err = e;
      q.push_back(ent);
    end

    @(posedge clk);
    #1;
    cyc++;
    m_stall = nstall;
    ev = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ent = q.pop_front();
      ev = 1'b1;
      m_rd = ent.rd; m_data = ent.data; m_err = ent.err;
    end
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, ev});
    chk("wb_rd",    {27'd0, wb_rd},    {27'd0, m_rd});
    chk("wb_data",  wb_data,           m_data);
    chk("wb_err",   {31'd0, wb_err},   {31'd0, m_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'b000, 32'd0, 5'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'h8899_AABB;
    mem[8'h11] = 32'h1122_3344;

    rst = 1'b1; req_valid = 1'b0; req_funct3 = 3'b000; req_addr = 32'd0; req_rd = 5'd0;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b1, 3'b010, 32'h40, 5'd9);   // request during reset is ignored
    cycle(1'b1, 1'b0, 3'b000, 32'd0, 5'd0);
    idle(1);

    // T1: byte loads
    cycle(1'b0, 1'b1, 3'b000, 32'h41, 5'd1);
    idle(2);
    cycle(1'b0, 1'b1, 3'b100, 32'h41, 5'd2);
    idle(2);
    // T2: half/word loads that stay within one word
    cycle(1'b0, 1'b1, 3'b001, 32'h42, 5'd3);
    cycle(1'b0, 1'b1, 3'b101, 32'h42, 5'd4);
    cycle(1'b0, 1'b1, 3'b010, 32'h40, 5'd5);
    idle(3);
    // T3: misaligned word across 0x43..0x46
    cycle(1'b0, 1'b1, 3'b010, 32'h43, 5'd6);
    cycle(1'b0, 1'b1, 3'b000, 32'h40, 5'd31);  // presented during stall, ignored
    idle(3);
    // T4: halfword at offset 3 splits, offset 2 does not
    cycle(1'b0, 1'b1, 3'b101, 32'h43, 5'd7);
    idle(1);
    cycle(1'b0, 1'b1, 3'b001, 32'h43, 5'd8);
    idle(1);
    cycle(1'b0, 1'b1, 3'b001, 32'h42, 5'd9);
    idle(3);
    // T5: back-to-back words, then an illegal funct3
    cycle(1'b0, 1'b1, 3'b010, 32'h40, 5'd10);
    cycle(1'b0, 1'b1, 3'b010, 32'h44, 5'd11);
    cycle(1'b0, 1'b1, 3'b010, 32'h48, 5'd12);
    cycle(1'b0, 1'b1, 3'b011, 32'h43, 5'd13);
    idle(3);
    // Split word at the top of the address space wraps to word 0
    cycle(1'b0, 1'b1, 3'b010, 32'hFFFF_FFFE, 5'd14);
    idle(4);
    // T6: reset while the second half of a split load is outstanding
    cycle(1'b0, 1'b1, 3'b010, 32'h43, 5'd15);
    cycle(1'b0, 1'b0, 3'b000, 32'd0, 5'd0);
    cycle(1'b1, 1'b0, 3'b000, 32'd0, 5'd0);
    cycle(1'b0, 1'b1, 3'b000, 32'h41, 5'd16);
    idle(3);

    // Random traffic, including occasional resets
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7),
            3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
